resta_pipe: RTL



---
 rtl/resta_pkg.sv | 25 ++
 rtl/resta_etapa.sv | 67 ++++++
 rtl/resta_pipe.sv | 80 ++++++++
 3 files changed

// File: rtl/resta_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resta_pkg
// Description : Shared defaults and the per-slice borrow subtract used by the
//               pipelined subtractor stages.
// Revision    : 1.0 - initial release
// ============================================================================
package resta_pkg;

    localparam int c_WIDTH  = 4;
    localparam int c_SLICE  = 2;
    localparam int c_NSTAGE = c_WIDTH / c_SLICE;

    // {borrow, diff} = a - b - bin; the extra MSB goes to 1 exactly when the
    // slice result is negative, which is the outgoing borrow.
    function automatic logic [c_SLICE:0] sub_slice(
        input logic [c_SLICE-1:0] a,
        input logic [c_SLICE-1:0] b,
        input logic               bin
    );
        return {1'b0, a} - {1'b0, b} - {{c_SLICE{1'b0}}, bin};
    endfunction

endpackage
`default_nettype wire

// File: rtl/resta_etapa.sv
`default_nettype none
// ============================================================================
// Module      : resta_etapa
// Description : One pipeline stage of the sliced subtractor. Subtracts the
//               lowest remaining slice, registers the borrow, the valid bit,
//               the shifted-down subtrahend and a combined minuend/result word.
// Revision    : 1.0 - initial release
// ============================================================================
module resta_etapa
    import resta_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int SLICE = c_SLICE   // slice helper is sized for c_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic             i_borrow,
    input  logic [WIDTH-1:0] i_x,       // unprocessed minuend slices low, finished diffs high
    input  logic [WIDTH-1:0] i_b,       // unprocessed subtrahend slices, current slice lowest
    output logic             o_valid,
    output logic             o_borrow,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_b
);

    logic [SLICE:0]   w_sub;
    logic [WIDTH-1:0] w_x_next;
    logic [WIDTH-1:0] w_b_next;

    logic             r_valid;
    logic             r_borrow;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_b;

    // Subtract the current slice; consumed minuend bits shift out the bottom
    // while the new difference slice enters at the top, so after the last
    // stage the word is exactly the full difference in natural order.
    always_comb begin
        w_sub    = sub_slice(i_x[SLICE-1:0], i_b[SLICE-1:0], i_borrow);
        w_x_next = (i_x >> SLICE) | (WIDTH'(w_sub[SLICE-1:0]) << (WIDTH - SLICE));
        w_b_next = i_b >> SLICE;
    end

    // Stage registers advance together under the global enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_borrow <= 1'b0;
            r_x      <= '0;
            r_b      <= '0;
        end else if (i_en) begin
            r_valid  <= i_valid;
            r_borrow <= w_sub[SLICE];
            r_x      <= w_x_next;
            r_b      <= w_b_next;
        end
    end

    assign o_valid  = r_valid;
    assign o_borrow = r_borrow;
    assign o_x      = r_x;
    assign o_b      = r_b;

endmodule
`default_nettype wire

// File: rtl/resta_pipe.sv
`default_nettype none
// ============================================================================
// Module      : resta_pipe
// Description : Pipelined unsigned subtractor, one SLICE-bit slice per stage,
//               with a valid/ready handshake on both sides and a global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module resta_pipe
    import resta_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,  // multiple of SLICE, >= SLICE
    parameter int SLICE = c_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] resta,
    output logic             prestamo
);

    localparam int c_STAGES = WIDTH / SLICE;

    logic             w_en;
    logic             w_valid  [0:c_STAGES];
    logic             w_borrow [0:c_STAGES];
    logic [WIDTH-1:0] w_x      [0:c_STAGES];
    logic [WIDTH-1:0] w_b      [0:c_STAGES-1];

    // Whole pipe moves when the output slot is free or being consumed.
    always_comb begin
        w_en        = ready_in | ~valid_out;
        w_valid[0]  = valid_in;
        w_borrow[0] = 1'b0;
        w_x[0]      = dataA;
        w_b[0]      = dataB;
    end

    generate
        for (genvar k = 0; k < c_STAGES; k++) begin : g_etapa
            logic [WIDTH-1:0] w_b_nxt;

            resta_etapa #(
                .WIDTH (WIDTH),
                .SLICE (SLICE)
            ) u_etapa (
                .clk      (clk),
                .reset    (reset),
                .i_en     (w_en),
                .i_valid  (w_valid[k]),
                .i_borrow (w_borrow[k]),
                .i_x      (w_x[k]),
                .i_b      (w_b[k]),
                .o_valid  (w_valid[k+1]),
                .o_borrow (w_borrow[k+1]),
                .o_x      (w_x[k+1]),
                .o_b      (w_b_nxt)
            );

            // The last stage has no subtrahend left to pass on.
            if (k < c_STAGES - 1) begin : g_mid
                assign w_b[k+1] = w_b_nxt;
            end else begin : g_last
                logic [WIDTH-1:0] w_b_unused;
                assign w_b_unused = w_b_nxt;
            end
        end
    endgenerate

    assign ready_out = w_en;
    assign valid_out = w_valid[c_STAGES];
    assign resta     = w_x[c_STAGES];
    assign prestamo  = w_borrow[c_STAGES];

endmodule
`default_nettype wire
